// File: rtl/fifo_write_arbiter.sv
// Two-producer write arbiter for a single fifo_stack write port.
// Grants one req/ack producer per two cycles; flags prolonged full back-pressure.
module fifo_write_arbiter #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned FAIR          = 1,
    parameter int unsigned FULL_WAIT_MAX = 16,
    parameter int unsigned CNT_WIDTH     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] A_DATA,
    input  logic                  A_REQ,
    output logic                  A_ACK,
    input  logic [DATA_WIDTH-1:0] B_DATA,
    input  logic                  B_REQ,
    output logic                  B_ACK,
    output logic [DATA_WIDTH-1:0] FIFO_DATA,
    output logic                  FIFO_SAVE,
    input  logic                  FIFO_FULL,
    output logic                  OVERFLOW,
    output logic                  LAST_GRANT
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(FULL_WAIT_MAX);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    typedef enum logic {
        IDLE = 1'b0,
        PUSH = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   data_d;
    logic                    save_d;
    logic                    a_ack_d;
    logic                    b_ack_d;
    logic                    ovf_d;
    logic                    last_d;
    logic                    grant_b_c;

    // B wins when it is alone, or on a round-robin tie after A was served last
    assign grant_b_c = B_REQ && (!A_REQ || ((FAIR != 0) && !LAST_GRANT));

    // Next-state and next-output decode
    always_comb begin
        state_d = IDLE;
        cnt_d   = cnt_q;
        data_d  = FIFO_DATA;
        save_d  = 1'b0;
        a_ack_d = 1'b0;
        b_ack_d = 1'b0;
        ovf_d   = OVERFLOW;
        last_d  = LAST_GRANT;

        case (state_q)
            IDLE: begin
                if (A_REQ || B_REQ) begin
                    if (!FIFO_FULL) begin
                        state_d = PUSH;
                        cnt_d   = '0;
                        save_d  = 1'b1;
                        last_d  = grant_b_c;
                        if (grant_b_c) begin
                            data_d  = B_DATA;
                            b_ack_d = 1'b1;
                        end else begin
                            data_d  = A_DATA;
                            a_ack_d = 1'b1;
                        end
                    end else begin
                        // Stall: count toward the overflow threshold, saturating
                        if (cnt_q >= CNT_MAX) begin
                            cnt_d = CNT_MAX;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                        if (cnt_d == CNT_MAX) begin
                            ovf_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            PUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            FIFO_DATA  <= '0;
            FIFO_SAVE  <= 1'b0;
            A_ACK      <= 1'b0;
            B_ACK      <= 1'b0;
            OVERFLOW   <= 1'b0;
            LAST_GRANT <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            FIFO_DATA  <= data_d;
            FIFO_SAVE  <= save_d;
            A_ACK      <= a_ack_d;
            B_ACK      <= b_ack_d;
            OVERFLOW   <= ovf_d;
            LAST_GRANT <= last_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter: a round-robin and a fixed-priority
// instance, each checked every cycle against a behavioural model.
module tb_fifo_write_arbiter;

    localparam int unsigned DW   = 8;
    localparam int          WMAX = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          fifo_full;
    logic          a_req  [2];
    logic          b_req  [2];
    logic [DW-1:0] a_data [2];
    logic [DW-1:0] b_data [2];

    logic          a_ack_0, b_ack_0, save_0, ovf_0, last_0;
    logic          a_ack_1, b_ack_1, save_1, ovf_1, last_1;
    logic [DW-1:0] data_0, data_1;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    fifo_write_arbiter #(.DATA_WIDTH(DW), .FAIR(1), .FULL_WAIT_MAX(WMAX), .CNT_WIDTH(5)) dut_rr (
        .clk(clk), .reset(reset),
        .A_DATA(a_data[0]), .A_REQ(a_req[0]), .A_ACK(a_ack_0),
        .B_DATA(b_data[0]), .B_REQ(b_req[0]), .B_ACK(b_ack_0),
        .FIFO_DATA(data_0), .FIFO_SAVE(save_0), .FIFO_FULL(fifo_full),
        .OVERFLOW(ovf_0), .LAST_GRANT(last_0)
    );

    fifo_write_arbiter #(.DATA_WIDTH(DW), .FAIR(0), .FULL_WAIT_MAX(WMAX), .CNT_WIDTH(5)) dut_fp (
        .clk(clk), .reset(reset),
        .A_DATA(a_data[1]), .A_REQ(a_req[1]), .A_ACK(a_ack_1),
        .B_DATA(b_data[1]), .B_REQ(b_req[1]), .B_ACK(b_ack_1),
        .FIFO_DATA(data_1), .FIFO_SAVE(save_1), .FIFO_FULL(fifo_full),
        .OVERFLOW(ovf_1), .LAST_GRANT(last_1)
    );

    // Behavioural model; index 0 is round-robin, index 1 is fixed priority
    bit          started = 1'b0;
    bit          m_busy [2];
    bit          m_save [2];
    bit          m_aack [2];
    bit          m_back [2];
    bit          m_ovf  [2];
    bit          m_last [2];
    logic [DW-1:0] m_data [2];
    int          m_stall[2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit win_b;
            if (!reset) begin
                m_busy[i] = 0; m_save[i] = 0; m_aack[i] = 0; m_back[i] = 0;
                m_ovf[i] = 0; m_last[i] = 1; m_data[i] = '0; m_stall[i] = 0;
            end else if (m_busy[i]) begin
                m_busy[i] = 0; m_save[i] = 0; m_aack[i] = 0; m_back[i] = 0;
            end else begin
                m_save[i] = 0; m_aack[i] = 0; m_back[i] = 0;
                if (!a_req[i] && !b_req[i]) begin
                    m_stall[i] = 0;
                end else if (fifo_full) begin
                    m_stall[i] = (m_stall[i] + 1 > WMAX) ? WMAX : m_stall[i] + 1;
                    if (m_stall[i] == WMAX) m_ovf[i] = 1;
                end else begin
                    if (a_req[i] && b_req[i]) win_b = (i == 0) ? !m_last[i] : 1'b0;
                    else                      win_b = b_req[i];
                    m_data[i]  = win_b ? b_data[i] : a_data[i];
                    m_aack[i]  = !win_b;
                    m_back[i]  = win_b;
                    m_save[i]  = 1;
                    m_last[i]  = win_b;
                    m_stall[i] = 0;
                    m_busy[i]  = 1;
                end
            end
        end
        started = 1'b1;
    end

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, i, act, exp, $time);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            chk("A_ACK",      0, 32'(a_ack_0), 32'(m_aack[0]));
            chk("B_ACK",      0, 32'(b_ack_0), 32'(m_back[0]));
            chk("FIFO_SAVE",  0, 32'(save_0),  32'(m_save[0]));
            chk("FIFO_DATA",  0, 32'(data_0),  32'(m_data[0]));
            chk("OVERFLOW",   0, 32'(ovf_0),   32'(m_ovf[0]));
            chk("LAST_GRANT", 0, 32'(last_0),  32'(m_last[0]));
            chk("A_ACK",      1, 32'(a_ack_1), 32'(m_aack[1]));
            chk("B_ACK",      1, 32'(b_ack_1), 32'(m_back[1]));
            chk("FIFO_SAVE",  1, 32'(save_1),  32'(m_save[1]));
            chk("FIFO_DATA",  1, 32'(data_1),  32'(m_data[1]));
            chk("OVERFLOW",   1, 32'(ovf_1),   32'(m_ovf[1]));
            chk("LAST_GRANT", 1, 32'(last_1),  32'(m_last[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_all(input logic ar, input logic [DW-1:0] ad, input logic br, input logic [DW-1:0] bd);
        for (int i = 0; i < 2; i++) begin
            a_req[i] = ar; a_data[i] = ad; b_req[i] = br; b_data[i] = bd;
        end
    endtask

    initial begin
        reset = 1'b0;
        fifo_full = 1'b0;
        set_all(1'b0, 8'h00, 1'b0, 8'h00);
        tick(); tick();
        chk("rst LAST_GRANT", 0, 32'(last_0), 32'd1);
        chk("rst OVERFLOW",   0, 32'(ovf_0),  32'd0);

        // Single A write after reset
        reset = 1'b1;
        set_all(1'b1, 8'h48, 1'b0, 8'h00);
        tick();
        chk("H FIFO_SAVE",  0, 32'(save_0),  32'd1);
        chk("H FIFO_DATA",  0, 32'(data_0),  32'h48);
        chk("H A_ACK",      0, 32'(a_ack_0), 32'd1);
        chk("H B_ACK",      0, 32'(b_ack_0), 32'd0);
        chk("H LAST_GRANT", 0, 32'(last_0),  32'd0);
        set_all(1'b0, 8'h48, 1'b0, 8'h00);
        tick();
        chk("H strobe off", 0, 32'(save_0),  32'd0);
        chk("H ack off",    0, 32'(a_ack_0), 32'd0);

        // Both producers request continuously
        set_all(1'b1, 8'h6F, 1'b1, 8'h6C);
        tick();
        chk("tie first data", 0, 32'(data_0), 32'h6C);
        chk("tie first data", 1, 32'(data_1), 32'h6F);
        tick(); tick();
        chk("tie second data", 0, 32'(data_0), 32'h6F);
        chk("fp B_ACK",        1, 32'(b_ack_1), 32'd0);
        repeat (8) tick();
        for (int i = 0; i < 2; i++) a_req[i] = 1'b0;
        repeat (4) tick();
        set_all(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) tick();

        // Full stall until overflow, then release
        fifo_full = 1'b1;
        set_all(1'b1, 8'h41, 1'b0, 8'h00);
        repeat (WMAX - 1) tick();
        chk("stall OVERFLOW pre", 0, 32'(ovf_0),  32'd0);
        chk("stall FIFO_SAVE",    0, 32'(save_0), 32'd0);
        tick();
        chk("stall OVERFLOW set", 0, 32'(ovf_0),  32'd1);
        fifo_full = 1'b0;
        tick();
        chk("release FIFO_DATA", 0, 32'(data_0), 32'h41);
        chk("release OVERFLOW",  0, 32'(ovf_0),  32'd1);
        set_all(1'b0, 8'h41, 1'b0, 8'h00);
        repeat (2) tick();

        // Reset asserted in the PUSH cycle with A still requesting
        set_all(1'b1, 8'h52, 1'b0, 8'h00);
        tick();
        reset = 1'b0;
        tick();
        chk("midrst FIFO_SAVE",  0, 32'(save_0), 32'd0);
        chk("midrst OVERFLOW",   0, 32'(ovf_0),  32'd0);
        chk("midrst LAST_GRANT", 0, 32'(last_0), 32'd1);
        reset = 1'b1;
        tick();
        chk("postrst FIFO_DATA", 0, 32'(data_0), 32'h52);
        chk("postrst A_ACK",     0, 32'(a_ack_0), 32'd1);
        set_all(1'b0, 8'h52, 1'b0, 8'h00);
        repeat (2) tick();

        // Full rises while a write is in flight; the other requester waits
        set_all(1'b1, 8'h31, 1'b1, 8'h32);
        tick();
        for (int i = 0; i < 2; i++) begin
            if (m_aack[i]) a_req[i] = 1'b0;
            if (m_back[i]) b_req[i] = 1'b0;
        end
        fifo_full = 1'b1;
        tick();
        repeat (4) begin
            tick();
            chk("full wait FIFO_SAVE", 0, 32'(save_0), 32'd0);
        end
        fifo_full = 1'b0;
        tick();
        chk("full drop FIFO_SAVE", 0, 32'(save_0), 32'd1);
        set_all(1'b0, 8'h00, 1'b0, 8'h00);
        repeat (2) tick();

        // Random traffic obeying the producer handshake rule
        repeat (3000) begin
            tick();
            for (int i = 0; i < 2; i++) begin
                if (a_req[i] && m_aack[i]) begin
                    if ($urandom_range(0, 1) == 0) a_req[i] = 1'b0;
                    else a_data[i] = DW'($urandom);
                end else if (!a_req[i] && $urandom_range(0, 9) < 3) begin
                    a_req[i] = 1'b1; a_data[i] = DW'($urandom);
                end
                if (b_req[i] && m_back[i]) begin
                    if ($urandom_range(0, 1) == 0) b_req[i] = 1'b0;
                    else b_data[i] = DW'($urandom);
                end else if (!b_req[i] && $urandom_range(0, 9) < 3) begin
                    b_req[i] = 1'b1; b_data[i] = DW'($urandom);
                end
            end
            if ($urandom_range(0, 9) == 0) fifo_full = ~fifo_full;
            reset = ($urandom_range(0, 299) != 0);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares one fifo_stack write port between two byte producers: A (USB3300 parser data path) and B (status/log generator).
- Each producer uses a req/ack handshake. The arbiter grants one producer at a time, round-robin or fixed priority, and drives the FIFO `save`/`I_DATA` inputs.
- Holds off while the FIFO reports full, and flags prolonged back-pressure with a sticky overflow bit.

Parameters:
- DATA_WIDTH, 8: width of producer and FIFO data.
- FAIR, 1: 1 = round-robin between A and B; 0 = fixed priority, A always wins.
- FULL_WAIT_MAX, 16: consecutive full-stalled cycles with a request pending before OVERFLOW sets (>= 1).
- CNT_WIDTH, 5: stall counter width; must hold FULL_WAIT_MAX.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- reset, input, 1: synchronous, active-low reset (0 = reset, sampled on rising clk).
- A_DATA, input, DATA_WIDTH: producer A byte; stable while A_REQ=1.
- A_REQ, input, 1: producer A request; held high until A_ACK is seen.
- A_ACK, output, 1: one-cycle pulse; A's byte was written.
- B_DATA, input, DATA_WIDTH: producer B byte; stable while B_REQ=1.
- B_REQ, input, 1: producer B request.
- B_ACK, output, 1: one-cycle pulse; B's byte was written.
- FIFO_DATA, output, DATA_WIDTH: to fifo_stack I_DATA.
- FIFO_SAVE, output, 1: to fifo_stack save; one-cycle write strobe.
- FIFO_FULL, input, 1: from fifo_stack full.
- OVERFLOW, output, 1: sticky back-pressure error flag.
- LAST_GRANT, output, 1: 0 = A was served last, 1 = B was served last.

Behaviour:
- **Registered outputs.** All outputs are registered.
- **Reset values.** While reset=0 at a clk edge, the block takes these values:
  - A_ACK=0, B_ACK=0, FIFO_SAVE=0, FIFO_DATA=0, OVERFLOW=0.
  - LAST_GRANT=1, so A wins the first tie.
  - Stall counter = 0, state = IDLE.
  - A request pending at reset is not acked; the producer keeps REQ high and is served after reset releases.
- **FSM states.** Two states: IDLE and PUSH.
- **IDLE, FIFO_FULL=0, any REQ=1.**
  - Select the winner:
    - Only one REQ high: that producer wins.
    - Both high, FAIR=1: winner = the producer not equal to LAST_GRANT.
    - Both high, FAIR=0: A wins.
  - Next edge: FIFO_DATA = winner DATA (sampled this cycle), FIFO_SAVE=1, winner ACK=1, LAST_GRANT = winner, counter = 0, state goes to PUSH.
- **IDLE, FIFO_FULL=1, any REQ=1.**
  - Stay in IDLE with no strobe and no ACK.
  - Counter increments, saturating at FULL_WAIT_MAX.
  - When the counter reaches FULL_WAIT_MAX, OVERFLOW is set to 1 on that edge.
- **IDLE, no REQ.** Counter = 0; stay in IDLE.
- **PUSH.** Lasts exactly one cycle. Next edge: FIFO_SAVE=0, A_ACK=0, B_ACK=0, state goes to IDLE. REQ is not evaluated in PUSH.
- **Timing.**
  - Latency: REQ sampled high in IDLE gives ACK/SAVE on the next cycle.
  - Maximum throughput is one byte per 2 cycles.
- **Producer rule.** On seeing ACK=1 at an edge, the producer deasserts REQ or presents the next byte at that same edge. This guarantees no double-write.
- **FIFO_DATA.** Holds its last value when not strobing.
- **FULL change.** FIFO_FULL rising during PUSH does not cancel the in-flight write; full is sampled only in IDLE.
- **OVERFLOW.** Cleared only by reset; it does not block further writes.
- **Simultaneous events.** A and B both request while the FIFO is full: neither is acked, LAST_GRANT is unchanged, and arbitration happens when full drops.

Test Plan:
- **Reset, then single A write.** reset=0 for 2 cycles, then 1; A_REQ=1, A_DATA="H".
  - Next cycle: FIFO_SAVE=1, FIFO_DATA=0x48, A_ACK=1, B_ACK=0, LAST_GRANT=0.
  - Following cycle: all strobes 0.
- **Round-robin, FAIR=1.** A and B hold REQ continuously with "o"/"l".
  - FIFO receives alternating 0x6F, 0x6C, starting with A (B when LAST_GRANT=0).
  - One SAVE every 2 cycles; ACKs never both high.
- **Fixed priority, FAIR=0, same stimulus.** Only A_ACK pulses; B_ACK stays 0 while A_REQ=1. B is served in the first IDLE after A drops REQ.
- **Full stall.** FIFO_FULL=1, A_REQ=1 for FULL_WAIT_MAX=16 cycles.
  - No SAVE; OVERFLOW rises exactly on the 16th stalled edge.
  - Drop FULL: write of A_DATA occurs next cycle; OVERFLOW stays 1.
- **Reset mid-operation.** Assert reset=0 in the PUSH cycle.
  - Next edge: FIFO_SAVE=0, ACKs=0, OVERFLOW=0, LAST_GRANT=1.
  - Held A_REQ is served 1 cycle after reset releases.
- **Full rises during PUSH.** FIFO_FULL goes to 1 in the PUSH cycle.
  - In-flight SAVE completes.
  - The next pending B request waits with no SAVE until FULL=0.
